// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// freq_meter - windowed zero-crossing counter with hysteresis; define
// FREQ_METER_AVG_EN to publish the floor average of the last 4 window counts.
// Revision 1.0
// ============================================================================
module freq_meter #(
  parameter int SAMPLE_W   = 4,
  parameter int CNT_W      = 10,
  parameter int WIN_CYCLES = 1600,
  parameter int HYST       = 0
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                stop,
  input  logic                edge_mode,
  input  logic [SAMPLE_W-1:0] signal,
  output logic [CNT_W-1:0]    result,
  output logic                result_valid,
  output logic                result_sat
);

  localparam int WIN_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WIN_W-1:0] c_win_last = WIN_W'(WIN_CYCLES - 1);
  localparam logic signed [SAMPLE_W-1:0] c_hyst_pos = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] c_hyst_neg = SAMPLE_W'(-HYST);

  localparam logic [1:0] S_UNK = 2'd0;
  localparam logic [1:0] S_P   = 2'd1;
  localparam logic [1:0] S_N   = 2'd2;

  logic [WIN_W-1:0] r_win;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             w_pos;
  logic             w_neg;
  logic             w_rise;
  logic             w_fall;
  logic             w_inc;
  logic             w_cnt_full;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat_nxt;
  logic             w_term;
  logic             w_publish;

  // Samples inside the hysteresis band classify as neither POS nor NEG.
  assign w_pos = $signed(signal) >= c_hyst_pos;
  assign w_neg = $signed(signal) <  c_hyst_neg;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= S_UNK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_UNK: begin
        if (w_pos)      w_state_nxt = S_P;
        else if (w_neg) w_state_nxt = S_N;
      end
      S_P:     if (w_neg) w_state_nxt = S_N;
      S_N:     if (w_pos) w_state_nxt = S_P;
      default: w_state_nxt = S_UNK;
    endcase
  end

  always_comb begin
    w_rise = 1'b0;
    w_fall = 1'b0;
    case (r_state)
      S_P:     w_fall = w_neg;
      S_N:     w_rise = w_pos;
      default: ;
    endcase
  end

  assign w_inc      = w_rise | (w_fall & ~edge_mode);
  assign w_cnt_full = &r_cnt;
  assign w_cnt_nxt  = (w_inc && !w_cnt_full) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_sat_nxt  = r_sat | (w_inc & w_cnt_full);
  assign w_term     = (r_win == c_win_last);
  assign w_publish  = w_term & ~stop;

  always_ff @(posedge clk) begin
    if (RESET || w_term) begin
      r_win <= '0;
    end else begin
      r_win <= r_win + WIN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RESET || stop || w_term) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= w_sat_nxt;
    end
  end

`ifdef FREQ_METER_AVG_EN
  // The window being closed is the newest of the 4; the 3 before it are stored.
  logic [CNT_W-1:0]   r_hist [0:2];
  logic [2:0]         r_hist_sat;
  logic [2:0]         r_fill;
  logic [CNT_W+1:0]   w_sum;
  logic               w_sat_or;
  logic               w_avg_ready;

  assign w_sum = (CNT_W+2)'(w_cnt_nxt) + (CNT_W+2)'(r_hist[0])
               + (CNT_W+2)'(r_hist[1]) + (CNT_W+2)'(r_hist[2]);
  assign w_sat_or    = w_sat_nxt | (|r_hist_sat);
  assign w_avg_ready = (r_fill >= 3'd3);

  always_ff @(posedge clk) begin
    if (RESET || stop) begin
      r_hist[0]  <= '0;
      r_hist[1]  <= '0;
      r_hist[2]  <= '0;
      r_hist_sat <= '0;
      r_fill     <= '0;
    end else if (w_publish) begin
      r_hist[0]  <= w_cnt_nxt;
      r_hist[1]  <= r_hist[0];
      r_hist[2]  <= r_hist[1];
      r_hist_sat <= {r_hist_sat[1:0], w_sat_nxt};
      r_fill     <= w_avg_ready ? 3'd4 : r_fill + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      result       <= '0;
      result_sat   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= w_publish & w_avg_ready;
      if (w_publish && w_avg_ready) begin
        result     <= w_sum[CNT_W+1:2];
        result_sat <= w_sat_or;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (RESET) begin
      result       <= '0;
      result_sat   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= w_publish;
      if (w_publish) begin
        result     <= w_cnt_nxt;
        result_sat <= w_sat_nxt;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter SAMPLE_W, default 4: width of signed input sample.
REQ-002 Parameter CNT_W, default 10: width of crossing counter and result.
REQ-003 Parameter WIN_CYCLES, default 1600: measurement window length in clk cycles, legal range 2..65535.
REQ-004 Parameter HYST, default 0: hysteresis threshold magnitude, legal range 0..2^(SAMPLE_W-1)-1.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 stop  input  1  level; while high, the crossing count is held at zero and no result is published.
REQ-008 edge_mode  input  1  0 = count both crossing directions, 1 = count negative-to-positive crossings only.
REQ-009 signal  input  SAMPLE_W  signed two's-complement sample, one per cycle.
REQ-010 result  output  CNT_W  last published crossing count.
REQ-011 result_valid  output  1  one-cycle pulse when result updates.
REQ-012 result_sat  output  1  set with result; high if that window's count saturated.

Function
REQ-013 Window counter shall be free-running: it counts 0..WIN_CYCLES-1, wraps to 0, and is unaffected by stop and edge_mode.
REQ-014 Terminal cycle is defined as window counter == WIN_CYCLES-1.
REQ-015 Region classification per sample: POS if signal >= HYST; NEG if signal < -HYST; otherwise HOLD.
REQ-016 Sign tracker FSM states: UNK, P, N; reset state UNK.
REQ-017 UNK->P on POS, UNK->N on NEG, no crossing counted; HOLD keeps the current state.
REQ-018 P->N on NEG is a falling crossing; N->P on POS is a rising crossing; HOLD never changes state.
REQ-019 A crossing increments the count when edge_mode=0 for either direction; when edge_mode=1, only for rising crossings.
REQ-020 Count shall saturate at 2^CNT_W-1; any further crossing in the same window sets an internal sat flag.
REQ-021 On a terminal cycle with stop low: publish count plus that cycle's increment (saturating) to result, and the sat flag (including that cycle's) to result_sat; pulse result_valid on the next cycle; clear count and sat flag.
REQ-022 On a terminal cycle with stop high: result and result_sat hold; result_valid stays low; count and sat flag clear.
REQ-023 While stop is high, count and sat flag are forced to 0 every cycle; the sign tracker keeps running.
REQ-024 A crossing on the same cycle stop deasserts is counted.
REQ-025 Latency: result, result_sat and result_valid shall be registered and change together on the cycle after the terminal cycle.
REQ-026 edge_mode changes take effect on the next sample, with no flush of count.

Reset
REQ-027 RESET high for one edge: window counter 0, count 0, sat flag 0, FSM UNK, result 0, result_sat 0, result_valid 0.
REQ-028 RESET has priority over all inputs; RESET mid-window discards the partial count and restarts the window from 0.

Configuration
REQ-029 Macro FREQ_METER_AVG_EN: when defined, the published result shall be the floor average of the last 4 window counts.
REQ-030 The average shall use a 4-entry history with a sum of width CNT_W+2, and result = sum >> 2.
REQ-031 With FREQ_METER_AVG_EN defined: result_sat = OR of the 4 entries' sat flags.
REQ-032 With FREQ_METER_AVG_EN defined: result_valid is suppressed until 4 windows have been accumulated since RESET or since the last stop-high cycle.
REQ-033 With FREQ_METER_AVG_EN defined: stop high clears the history and its fill count.
REQ-034 Without FREQ_METER_AVG_EN, result is the raw window count per REQ-021, and no history logic is present.

Verification (bench: WIN_CYCLES=16, SAMPLE_W=4, CNT_W=4, HYST=2)
REQ-035 Square wave +4/-4 with period 4 cycles, edge_mode=0 -> result 8 (transitions inside window), result_valid pulses every 16 cycles.
REQ-036 Same wave with edge_mode=1 -> result 4; a +1/-1 noise-only input -> result 0 (hysteresis).
REQ-037 Toggle +4/-4 every cycle -> count saturates at 15, result=15, result_sat=1.
REQ-038 stop high across a terminal cycle -> result unchanged and no result_valid pulse; stop released at window start -> next result matches the full-window count.
REQ-039 RESET at window counter=9 -> all outputs 0, next result_valid exactly 17 cycles after RESET deassert edge.
REQ-040 FREQ_METER_AVG_EN with window counts 4,8,8,12 -> first result_valid after 4th window with result 8, then tracks the running average.
